ushift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal shift register.
- Supports hold, parallel load, logical shift left/right with serial input, rotate left/right, and synchronous clear.
- Tracks how many bits have been shifted out since the last load, so it can serve as a parallel-to-serial converter.
- Sits between parallel datapaths and bit-serial links.

---
 rtl/ushift_reg.sv | 127 ++++++++++++
 tb/tb_ushift_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ushift_reg.sv
// Purpose : WIDTH-bit universal shift register (hold/load/shift/rotate/clear) with shift-out counter.
// Latency : 1 core clock from mode/d/sin sampled to q, shift_cnt, empty (and parity) updated.
// Backpr. : none; shift data is never blocked, en=0 is the only stall and freezes all state.
//
// Ports:
//   clk            rising-edge clock
//   async_reset_n  asynchronous active-low reset (assert async, release sync to clk)
//   en             clock enable; 0 holds q, shift_cnt, empty regardless of mode
//   mode[2:0]      000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 CLEAR, 111 HOLD
//   d[WIDTH-1:0]   parallel load data
//   sin            serial input for SHL/SHR
//   q              register contents
//   sout_msb/lsb   q[WIDTH-1] / q[0], combinational from q
//   shift_cnt      shifts since last load, saturating at WIDTH
//   empty          registered, 1 when shift_cnt==WIDTH
//   parity         only with `define USHIFT_PARITY_EN: registered XOR reduction of q
module ushift_reg #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    localparam int                CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               async_reset_n,
    input  logic               en,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               sin,
    output logic [WIDTH-1:0]   q,
    output logic               sout_msb,
    output logic               sout_lsb,
    output logic [CNT_W-1:0]   shift_cnt,
    output logic               empty
`ifdef USHIFT_PARITY_EN
    ,
    output logic               parity
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_empty;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Logical shifts count towards WIDTH and then stick there; the data still moves.
    assign w_cnt_inc = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        case (mode_e'(mode))
            MODE_LOAD: begin
                w_q_nxt   = d;
                w_cnt_nxt = '0;
            end
            MODE_SHL: begin
                w_q_nxt   = {r_q[WIDTH-2:0], sin};
                w_cnt_nxt = w_cnt_inc;
            end
            MODE_SHR: begin
                w_q_nxt   = {sin, r_q[WIDTH-1:1]};
                w_cnt_nxt = w_cnt_inc;
            end
            // Rotates lose no data, so the shift-out count is left alone.
            MODE_ROL: w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROR: w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            MODE_CLEAR: begin
                w_q_nxt   = RESET_VALUE;
                w_cnt_nxt = CNT_FULL;
            end
            default: begin
                // HOLD and the reserved code keep everything.
                w_q_nxt   = r_q;
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_q     <= RESET_VALUE;
            r_cnt   <= CNT_FULL;
            r_empty <= 1'b1;
        end else if (en) begin
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            // Derived from the next count so empty never lags shift_cnt.
            r_empty <= (w_cnt_nxt == CNT_FULL);
        end
    end

`ifdef USHIFT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_parity <= ^RESET_VALUE;
        end else if (en) begin
            r_parity <= ^w_q_nxt;
        end
    end

    assign parity = r_parity;
`endif

    assign q         = r_q;
    assign sout_msb  = r_q[WIDTH-1];
    assign sout_lsb  = r_q[0];
    assign shift_cnt = r_cnt;
    assign empty     = r_empty;

endmodule

// File: tb/tb_ushift_reg.sv
// Purpose : directed-vector scoreboard bench for ushift_reg (WIDTH=8, RESET_VALUE=0).
// Latency : expectations are queued one clock after each issued operation.
// Backpr. : none; the monitor drains the queue on every falling edge or async-reset event.
module tb_ushift_reg;

    localparam int WIDTH = 8;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_RSVD  = 3'b111;

    logic             clk;
    logic             async_reset_n;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic [3:0]       shift_cnt;
    logic             empty;
`ifdef USHIFT_PARITY_EN
    logic             parity;
`endif

    ushift_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .en            (en),
        .mode          (mode),
        .d             (d),
        .sin           (sin),
        .q             (q),
        .sout_msb      (sout_msb),
        .sout_lsb      (sout_lsb),
        .shift_cnt     (shift_cnt),
        .empty         (empty)
`ifdef USHIFT_PARITY_EN
        ,
        .parity        (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       empty;
        string      name;
    } exp_t;

    exp_t sb[$];
    event ev_async;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the stimulus has queued, decoupled from issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_async);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q"},         64'(q),         64'(e.q));
                check({e.name, ".shift_cnt"}, 64'(shift_cnt), 64'(e.cnt));
                check({e.name, ".empty"},     64'(empty),     64'(e.empty));
                check({e.name, ".sout_msb"},  64'(sout_msb),  64'(e.q[7]));
                check({e.name, ".sout_lsb"},  64'(sout_lsb),  64'(e.q[0]));
`ifdef USHIFT_PARITY_EN
                check({e.name, ".parity"},    64'(parity),    64'(^e.q));
`endif
            end
        end
    end

    task automatic push(input logic [7:0] eq, input logic [3:0] ecnt, input logic eempty,
                        input string name);
        exp_t e;
        e.q     = eq;
        e.cnt   = ecnt;
        e.empty = eempty;
        e.name  = name;
        sb.push_back(e);
    endtask

    // One clocked operation: drive on the falling edge, queue the post-edge expectation.
    task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s,
                      input logic [7:0] eq, input logic [3:0] ecnt, input logic eempty,
                      input string name);
        @(negedge clk);
        en   = e;
        mode = m;
        d    = dv;
        sin  = s;
        @(posedge clk);
        #1;
        push(eq, ecnt, eempty, name);
    endtask

    // Reset asserted mid-period and checked before any rising edge can occur.
    task automatic async_reset(input string name);
        @(negedge clk);
        en = 1'b0;
        #2;
        async_reset_n = 1'b0;
        #1;
        push(8'h00, 4'd8, 1'b1, name);
        -> ev_async;
        @(negedge clk);
        #1;
        async_reset_n = 1'b1;
    endtask

    // Hand-computed SHL trace of 8'hA5 with sin=0.
    logic [7:0] shl_q [8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};

    initial begin
        async_reset_n = 1'b1;
        en            = 1'b0;
        mode          = M_HOLD;
        d             = '0;
        sin           = 1'b0;

        async_reset("reset");

        // LOAD then eight SHL: sout_msb before each edge is 1,0,1,0,0,1,0,1.
        op(1, M_LOAD, 8'hA5, 0, 8'hA5, 4'd0, 0, "load_a5");
        for (int i = 0; i < 8; i++)
            op(1, M_SHL, 8'h00, 0, shl_q[i], 4'(i + 1), (i == 7), $sformatf("shl%0d", i + 1));

        // Saturated: data keeps moving, count stays at 8.
        op(1, M_SHL, 8'h00, 1, 8'h01, 4'd8, 1, "shl_sat1");
        op(1, M_SHL, 8'h00, 1, 8'h03, 4'd8, 1, "shl_sat2");
        op(1, M_CLEAR, 8'h55, 0, 8'h00, 4'd8, 1, "clear1");

        // SHR with sin=1.
        op(1, M_LOAD, 8'h0F, 0, 8'h0F, 4'd0, 0, "load_0f");
        op(1, M_SHR, 8'h00, 1, 8'h87, 4'd1, 0, "shr1");
        op(1, M_SHR, 8'h00, 1, 8'hC3, 4'd2, 0, "shr2");
        op(1, M_SHR, 8'h00, 1, 8'hE1, 4'd3, 0, "shr3");

        // Enable low freezes everything whatever the mode.
        for (int i = 0; i < 5; i++)
            op(0, M_SHL, 8'h00, 1, 8'hE1, 4'd3, 0, $sformatf("en0_shl%0d", i));
        op(0, M_LOAD,  8'h5A, 0, 8'hE1, 4'd3, 0, "en0_load");
        op(0, M_CLEAR, 8'h00, 0, 8'hE1, 4'd3, 0, "en0_clear");
        op(1, M_RSVD,  8'h5A, 1, 8'hE1, 4'd3, 0, "reserved");
        op(1, M_HOLD,  8'h5A, 1, 8'hE1, 4'd3, 0, "hold");

        // Rotates leave the count at 0.
        op(1, M_LOAD, 8'h81, 0, 8'h81, 4'd0, 0, "load_81");
        op(1, M_ROL,  8'h00, 1, 8'h03, 4'd0, 0, "rol1");
        op(1, M_ROR,  8'h00, 1, 8'h81, 4'd0, 0, "ror1");
        op(1, M_ROR,  8'h00, 1, 8'hC0, 4'd0, 0, "ror2");

        // LOAD while empty clears empty on the next edge.
        op(1, M_CLEAR, 8'h00, 0, 8'h00, 4'd8, 1, "clear2");
        op(1, M_LOAD,  8'h3C, 0, 8'h3C, 4'd0, 0, "load_empty");

        // Reset in the middle of a shift sequence.
        op(1, M_LOAD, 8'hFF, 0, 8'hFF, 4'd0, 0, "load_ff");
        op(1, M_SHR,  8'h00, 0, 8'h7F, 4'd1, 0, "shrff1");
        op(1, M_SHR,  8'h00, 0, 8'h3F, 4'd2, 0, "shrff2");
        op(1, M_SHR,  8'h00, 0, 8'h1F, 4'd3, 0, "shrff3");
        op(1, M_SHR,  8'h00, 0, 8'h0F, 4'd4, 0, "shrff4");
        async_reset("reset_mid");

        // Odd-weight load: parity (when built) must read 1.
        op(1, M_LOAD, 8'h07, 0, 8'h07, 4'd0, 0, "load_07");
        op(1, M_SHL,  8'h00, 0, 8'h0E, 4'd1, 0, "shl_07");

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
